// File: rtl/aes_inv_key_schedule.sv
// AES-128 inverse key expansion: loaded with the round-10 key, emits round keys
// 10 down to 0 over a valid/ready handshake, one backward step per accepted key.
module aes_inv_key_schedule #(
  parameter int NUM_ROUNDS = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] ip_key,
  output logic         key_valid,
  input  logic         key_ready,
  output logic [127:0] op_key,
  output logic [3:0]   rndNo,
  output logic         busy,
  output logic         done,
  output logic [1:0]   o_dbg_state
);

  if (NUM_ROUNDS != 10) begin : g_bad_rounds
    $error("aes_inv_key_schedule supports only NUM_ROUNDS=10");
  end

  localparam logic [3:0] LAST_RND = 4'(NUM_ROUNDS);

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {IDLE = 2'd0, EMIT = 2'd1, STEP = 2'd2} state_t;

  state_t       r_state;
  state_t       w_next_state;
  logic [127:0] r_key;
  logic [3:0]   r_rnd;
  logic         r_done;
  logic         w_load;
  logic         w_step;
  logic         w_last;

  logic [31:0]  w_w0, w_w1, w_w2, w_w3;
  logic [31:0]  w_p0, w_p1, w_p2, w_p3;
  logic [31:0]  w_rot;
  logic [31:0]  w_sub;
  logic [7:0]   w_rc;
  logic [127:0] w_prev_key;

  function automatic logic [7:0] sbox(input logic [7:0] a);
    return SBOX[a];
  endfunction

  // Handshake: a key transfers on a rising edge where key_valid && key_ready;
  // op_key/rndNo are held while key_valid is high and key_ready is low.
  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_step       = 1'b0;
    w_last       = 1'b0;
    case (r_state)
      IDLE: begin
        // The done cycle is the hand-off cycle; a start seen then is dropped.
        if (start && !r_done) begin
          w_load       = 1'b1;
          w_next_state = EMIT;
        end
      end
      EMIT: begin
        if (key_ready) begin
          if (r_rnd == 4'd0) begin
            w_last       = 1'b1;
            w_next_state = IDLE;
          end else begin
            w_next_state = STEP;
          end
        end
      end
      STEP: begin
        w_step       = 1'b1;
        w_next_state = EMIT;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    w_rc = 8'h00;
    case (r_rnd)
      4'd1:  w_rc = 8'h01;
      4'd2:  w_rc = 8'h02;
      4'd3:  w_rc = 8'h04;
      4'd4:  w_rc = 8'h08;
      4'd5:  w_rc = 8'h10;
      4'd6:  w_rc = 8'h20;
      4'd7:  w_rc = 8'h40;
      4'd8:  w_rc = 8'h80;
      4'd9:  w_rc = 8'h1b;
      4'd10: w_rc = 8'h36;
      default: w_rc = 8'h00;
    endcase
  end

  // Undo the forward recurrence: later words first, then w0 from the recovered w3.
  assign w_w0       = r_key[127:96];
  assign w_w1       = r_key[95:64];
  assign w_w2       = r_key[63:32];
  assign w_w3       = r_key[31:0];
  assign w_p3       = w_w3 ^ w_w2;
  assign w_p2       = w_w2 ^ w_w1;
  assign w_p1       = w_w1 ^ w_w0;
  assign w_rot      = {w_p3[23:0], w_p3[31:24]};
  assign w_sub      = {sbox(w_rot[31:24]), sbox(w_rot[23:16]),
                       sbox(w_rot[15:8]), sbox(w_rot[7:0])};
  assign w_p0       = w_w0 ^ w_sub ^ {w_rc, 24'h0};
  assign w_prev_key = {w_p0, w_p1, w_p2, w_p3};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_key   <= '0;
      r_rnd   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_done  <= w_last;
      if (w_load) begin
        r_key <= ip_key;
        r_rnd <= LAST_RND;
      end else if (w_step) begin
        r_key <= w_prev_key;
        r_rnd <= r_rnd - 4'd1;
      end
    end
  end

  assign key_valid   = (r_state == EMIT);
  assign busy        = (r_state != IDLE);
  assign done        = r_done;
  assign op_key      = r_key;
  assign rndNo       = r_rnd;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_aes_inv_key_schedule.sv
// Directed bench for aes_inv_key_schedule: FIPS-197 chain, backpressure, ignored
// start, mid-run reset, back-to-back loads and idle behaviour.
module tb_aes_inv_key_schedule;

  localparam logic [127:0] K10     = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] K9      = 128'hac7766f319fadc2128d12941575c006e;
  localparam logic [127:0] K1      = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] K0      = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] ALT_KEY = 128'h00112233445566778899aabbccddeeff;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  localparam logic [0:10][7:0] RC = {8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                     8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  // clock / reset
  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] ip_key;
  logic         key_valid;
  logic         key_ready;
  logic [127:0] op_key;
  logic [3:0]   rndNo;
  logic         busy;
  logic         done;
  logic [1:0]   dbg_state;

  always #5 clk = ~clk;

  aes_inv_key_schedule #(.NUM_ROUNDS(10)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .ip_key     (ip_key),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .op_key     (op_key),
    .rndNo      (rndNo),
    .busy       (busy),
    .done       (done),
    .o_dbg_state(dbg_state)
  );

  // scoreboard
  int           n_checks = 0;
  int           n_errors = 0;
  logic [127:0] exp_q[$];
  logic [127:0] cap [0:10];
  logic [127:0] fwd [0:10];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] sb(input logic [7:0] a);
    return SBOX[a];
  endfunction

  // Forward AES-128 key expansion from a round-0 key into fwd[0..10].
  task automatic expand(input logic [127:0] k0);
    logic [31:0] w [0:43];
    logic [31:0] t;
    for (int i = 0; i < 4; i++) w[i] = k0[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb(t[31:24]), sb(t[23:16]), sb(t[15:8]), sb(t[7:0])} ^ {RC[i/4], 24'h0};
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) fwd[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic fill_sb();
    exp_q.delete();
    for (int r = 10; r >= 0; r--) exp_q.push_back(fwd[r]);
  endtask

  // driver tasks
  task automatic load(input logic [127:0] k);
    start  = 1'b1;
    ip_key = k;
    @(posedge clk); #1;
    start  = 1'b0;
    ip_key = ALT_KEY;
    check("start_latency", key_valid, 1);
  endtask

  task automatic drain(input int stall_at, input bit rand_ready, input int start_at,
                       input int rst_at, input bit use_sb, output int iters,
                       output bit aborted);
    int           n = 0;
    int           exp_rnd = 10;
    int           stall_left = 5;
    bit           stalled = 0;
    bit           start_sent = 0;
    bit           r;
    logic [127:0] held_key = '0;
    logic [3:0]   held_rnd = '0;
    iters   = 0;
    aborted = 0;
    while (n < 11 && iters < 300) begin
      start = 1'b0;
      if (stalled) begin
        check("stall_valid", key_valid, 1);
        check("stall_key", op_key, held_key);
        check("stall_rnd", rndNo, held_rnd);
      end
      if (key_valid) begin
        if (int'(rndNo) == rst_at) begin
          rst       = 1'b1;
          key_ready = 1'b0;
          aborted   = 1;
          break;
        end
        if (int'(rndNo) == stall_at && stall_left > 0) begin
          r = 0;
          stall_left--;
        end else if (rand_ready) r = 1'($urandom_range(0, 1));
        else r = 1;
        if (int'(rndNo) == start_at && !start_sent) begin
          start      = 1'b1;
          ip_key     = ALT_KEY;
          start_sent = 1;
        end
        key_ready = r;
        stalled   = !r;
        held_key  = op_key;
        held_rnd  = rndNo;
        if (r) begin
          check("xfer_rnd", rndNo, 128'(exp_rnd));
          if (rndNo <= 4'd10) cap[rndNo] = op_key;
          if (use_sb && exp_q.size() > 0) check("xfer_key", op_key, exp_q.pop_front());
          exp_rnd--;
          n++;
        end
      end else begin
        key_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        stalled   = 0;
      end
      @(posedge clk); #1;
      iters++;
    end
    start = 1'b0;
    if (aborted) begin
      @(posedge clk); #1;
      rst = 1'b0;
      check("rst_valid", key_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_key", op_key, 0);
      check("rst_rnd", rndNo, 0);
    end else begin
      check("xfer_count", 128'(n), 11);
    end
  endtask

  task automatic check_done_cycle();
    check("done_pulse", done, 1);
    check("done_busy", busy, 0);
    check("done_valid", key_valid, 0);
  endtask

  int iters;
  bit aborted;

  initial begin
    rst = 1'b1; start = 1'b0; key_ready = 1'b0; ip_key = '0;
    repeat (2) @(posedge clk); #1;
    check("reset_valid", key_valid, 0);
    check("reset_key", op_key, 0);
    check("reset_rnd", rndNo, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_state", dbg_state, 0);
    rst = 1'b0;

    expand(K0);
    check("model_r10", fwd[10], K10);

    // FIPS-197 chain with key_ready held high
    fill_sb();
    load(K10);
    drain(-1, 0, -1, -1, 1, iters, aborted);
    check_done_cycle();
    check("done_latency", 128'(iters), 21);
    check("fips_r10", cap[10], K10);
    check("fips_r9", cap[9], K9);
    check("fips_r1", cap[1], K1);
    check("fips_r0", cap[0], K0);
    start  = 1'b1;
    ip_key = ALT_KEY;
    @(posedge clk); #1;
    start = 1'b0;
    check("start_on_done_busy", busy, 0);
    check("done_one_cycle", done, 0);

    // back-to-back load of the all-zero round-10 key, cross-checked forward
    load('0);
    drain(-1, 1, -1, -1, 0, iters, aborted);
    check_done_cycle();
    check("zero_r10", cap[10], 0);
    expand(cap[0]);
    for (int r = 0; r < 11; r++) check($sformatf("zero_fwd_r%0d", r), cap[r], fwd[r]);
    @(posedge clk); #1;

    // backpressure at round 7, random ready afterwards
    expand(K0);
    fill_sb();
    load(K10);
    drain(7, 1, -1, -1, 1, iters, aborted);
    check_done_cycle();
    @(posedge clk); #1;

    // start with a different key while busy
    fill_sb();
    load(K10);
    drain(-1, 0, 5, -1, 1, iters, aborted);
    check_done_cycle();
    @(posedge clk); #1;

    // reset at round 4, then a fresh FIPS load
    fill_sb();
    load(K10);
    drain(-1, 0, -1, 4, 1, iters, aborted);
    check("rst_aborted", 128'(aborted), 1);
    fill_sb();
    load(K10);
    drain(-1, 0, -1, -1, 1, iters, aborted);
    check_done_cycle();
    check("reload_latency", 128'(iters), 21);
    check("reload_r0", cap[0], K0);
    @(posedge clk); #1;

    // idle: ready toggling, no start
    for (int i = 0; i < 12; i++) begin
      key_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      check("idle_valid", key_valid, 0);
      check("idle_busy", busy, 0);
      check("idle_done", done, 0);
      check("idle_key", op_key, K0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
